// File: rtl/mux_sel_sequencer_pkg.sv
// ============================================================================
// mux_sel_sequencer_pkg : shared states, select constants and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_sel_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] SEL_FIRST_LSB = 3'd0;
  localparam logic [2:0] SEL_LAST_LSB  = 3'd7;
  localparam int         DATA_W        = 8;

  // Select index that opens a byte for the chosen bit order.
  function automatic logic [2:0] sel_start(input bit msb_first);
    return msb_first ? SEL_LAST_LSB : SEL_FIRST_LSB;
  endfunction

  // Select index carried by the final bit of a byte.
  function automatic logic [2:0] sel_end(input bit msb_first);
    return msb_first ? SEL_FIRST_LSB : SEL_LAST_LSB;
  endfunction

  function automatic logic [2:0] sel_step(input logic [2:0] s, input bit msb_first);
    return msb_first ? (s - 3'd1) : (s + 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_sequencer_if.sv
// ============================================================================
// mux_sel_sequencer_if : load handshake plus downstream mux drive bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mux_sel_sequencer_if;
  import mux_sel_sequencer_pkg::*;

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              abort;
  logic [DATA_W-1:0] par_out;
  logic [2:0]        sel;
  logic              busy;
  logic              bit_strobe;
  logic              last;

  // Upstream producer / parent side.
  modport master (
    output load_valid, load_data, abort,
    input  load_ready, par_out, sel, busy, bit_strobe, last
  );

  // The sequencer itself.
  modport slave (
    input  load_valid, load_data, abort,
    output load_ready, par_out, sel, busy, bit_strobe, last
  );

endinterface

`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
// ============================================================================
// mux_sel_sequencer : holds a byte and steps an external 8:1 mux select
// through its bits, one bit every DIV clocks.  Rev 1.0
// ============================================================================
`default_nettype none

module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mux_sel_sequencer_if.slave  bus
);

  localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_MAX   = CNT_W'(DIV - 1);
  localparam logic [2:0]       SEL_START = sel_start(MSB_FIRST);
  localparam logic [2:0]       SEL_END   = sel_end(MSB_FIRST);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  w_div_cnt_nxt;
  logic [2:0]        r_sel;
  logic [2:0]        w_sel_nxt;
  logic [DATA_W-1:0] r_par;
  logic [DATA_W-1:0] w_par_nxt;

  logic w_strobe;
  logic w_last;
  logic w_ready;
  logic w_xfer;

  // Outputs decode only from state, counter and select.
  assign w_strobe = (r_state == SHIFT) && (r_div_cnt == DIV_MAX);
  assign w_last   = w_strobe && (r_sel == SEL_END);
  assign w_ready  = (r_state == IDLE) || w_last;
  assign w_xfer   = bus.load_valid && w_ready && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_sel     <= SEL_FIRST_LSB;
      r_par     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_par     <= w_par_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_sel_nxt     = r_sel;
    w_par_nxt     = r_par;

    if (bus.abort) begin
      // Cancel wins over any simultaneous load; the held byte stays visible.
      w_state_nxt   = IDLE;
      w_div_cnt_nxt = '0;
    end else if (w_xfer) begin
      w_state_nxt   = SHIFT;
      w_div_cnt_nxt = '0;
      w_sel_nxt     = SEL_START;
      w_par_nxt     = bus.load_data;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        w_state_nxt   = IDLE;
        w_div_cnt_nxt = '0;
      end else if (w_strobe) begin
        w_div_cnt_nxt = '0;
        w_sel_nxt     = sel_step(r_sel, MSB_FIRST);
      end else begin
        w_div_cnt_nxt = r_div_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.par_out    = r_par;
  assign bus.sel        = r_sel;
  assign bus.busy       = (r_state == SHIFT);
  assign bus.bit_strobe = w_strobe;
  assign bus.last       = w_last;

endmodule

`default_nettype wire

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 1, clock cycles per bit period (legal range 1..256).
REQ-002 SHALL have parameter MSB_FIRST, default 0, bit order (0: sel 0->7; 1: sel 7->0).
REQ-003 SHALL have port clk, input, 1, single clock for all state, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port load_valid, input, 1, upstream byte offered.
REQ-006 SHALL have port load_data, input, 8, byte to serialize.
REQ-007 SHALL have port load_ready, output, 1, block accepts a byte this cycle.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current byte.
REQ-009 SHALL have port par_out, output, 8, held byte, drives the downstream 8:1 mux data input.
REQ-010 SHALL have port sel, output, 3, bit index, drives the downstream 8:1 mux select.
REQ-011 SHALL have port busy, output, 1, high while a byte is being stepped.
REQ-012 SHALL have port bit_strobe, output, 1, one-cycle pulse on the last cycle of each bit period (sample point).
REQ-013 SHALL have port last, output, 1, high together with bit_strobe of the final bit only.

Function
REQ-014 SHALL implement states IDLE and SHIFT.
REQ-015 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only in the cycle where bit_strobe and last are both high; otherwise 0.
REQ-016 A transfer SHALL occur when load_valid and load_ready are both high and abort is low.
REQ-017 On transfer: par_out <= load_data; sel <= 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1); div_cnt <= 0; state <= SHIFT, all in the next cycle.
REQ-018 In SHIFT, div_cnt SHALL count 0..DIV-1 and wrap; bit_strobe = (state==SHIFT) and (div_cnt==DIV-1).
REQ-019 On bit_strobe with last low, sel SHALL step by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1) and div_cnt SHALL wrap to 0.
REQ-020 last SHALL be high when bit_strobe is high and sel is 7 (MSB_FIRST=0) or 0 (MSB_FIRST=1).
REQ-021 On bit_strobe with last high: with a transfer in the same cycle, SHIFT SHALL continue with the new byte per REQ-017 (no idle gap); otherwise state <= IDLE.
REQ-022 A byte SHALL occupy exactly 8*DIV cycles in SHIFT; back-to-back bytes SHALL give continuous bit_strobe spacing of DIV cycles.
REQ-023 sel and par_out SHALL be stable for a whole bit period and change only on clock edges following bit_strobe or a transfer.
REQ-024 In IDLE, par_out and sel SHALL hold their last values and bit_strobe and last SHALL be 0.
REQ-025 busy SHALL equal (state==SHIFT).
REQ-026 abort high SHALL force state <= IDLE and div_cnt <= 0 next cycle; abort SHALL win over a simultaneous transfer (no byte accepted); par_out and sel SHALL hold.
REQ-027 With DIV=1, bit_strobe SHALL be high every SHIFT cycle.
REQ-028 All outputs SHALL be registered or decoded only from state, div_cnt and sel (no combinational path from load_valid to any output other than none).

Reset
REQ-029 rst high SHALL asynchronously force state=IDLE, div_cnt=0, sel=0, par_out=8'h00.
REQ-030 During and after reset: load_ready=1, busy=0, bit_strobe=0, last=0; reset mid-byte SHALL discard the byte with no further strobes.
REQ-031 Reset release SHALL be synchronous to clk externally; the first transfer SHALL be possible on the first edge after release.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, SHIFT) and constants SEL_FIRST_LSB=3'd0 and SEL_LAST_LSB=3'd7.
REQ-033 The block SHALL be a single module; the bit-period counter SHALL be an inline counter, with no sub-module.
REQ-034 The block SHALL instantiate no mux; par_out and sel connect at the parent to the existing 8:1 mux.

Verification
REQ-035 DIV=1, MSB_FIRST=0, load 8'hA5 once: sel 0..7 on 8 consecutive cycles, mux out 1,0,1,0,0,1,0,1; last on the 8th strobe; IDLE next.
REQ-036 DIV=3, load 8'h3C: bit_strobe every 3rd cycle, 24 SHIFT cycles total, sel constant for 3 cycles each.
REQ-037 DIV=1, load_valid held with 8'hFF then 8'h00: load_ready high on the last strobe, 16 contiguous strobes, busy never drops.
REQ-038 MSB_FIRST=1, load 8'h80: sel 7..0, first sampled mux bit 1 and the rest 0; last at sel=0.
REQ-039 abort at bit 3 asserted together with load_valid: next cycle IDLE, no transfer, par_out and sel held, no strobe.
REQ-040 rst asserted mid-byte, asynchronously between edges: outputs go to reset values immediately; after release, load 8'h01 serializes normally.
